// File: rtl/bf16_dot_acc.sv
// BF16 dot-product engine: streams A*B products into an FP32 accumulator seeded by C
// or by the last delivered result, one beat per ACCEPT->MUL->ADD->RND pass.
module bf16_dot_acc #(
  parameter int WIDTH      = 16,
  parameter int SIG_WIDTH  = 7,
  parameter int CWIDTH     = 32,
  parameter int CSIG_WIDTH = 23,
  parameter int MAX_LEN    = 256,
  parameter int CNT_W      = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [CWIDTH-1:0] C,
  input  logic              c_sel,
  input  logic              in_last,
  input  logic [1:0]        rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] result,
  output logic [CNT_W-1:0]  count,
  output logic [3:0]        flags
);
  localparam int EW = WIDTH - SIG_WIDTH - 1;
  localparam int PW = 2 * (SIG_WIDTH + 1);
  localparam int SW = CSIG_WIDTH + 1;
  localparam int XW = SW + 4;

  typedef enum logic [2:0] {S_ACCEPT, S_MUL, S_ADD, S_RND, S_DONE} state_t;

  state_t                   state_q;
  logic                     first_q, in_ready_q, out_valid_q, last_q;
  logic [WIDTH-1:0]         a_q, b_q;
  logic [CWIDTH-1:0]        acc_q, chain_q;
  logic [1:0]               rnd_q;
  logic [CNT_W-1:0]         count_q;
  logic [3:0]               flags_q;
  logic                     p_sign_q, p_zero_q, p_inf_q, p_nan_q;
  logic signed [11:0]       p_exp_q;
  logic [SW-1:0]            p_sig_q;
  logic [XW-1:0]            s_sum_q;
  logic signed [11:0]       s_exp_q;
  logic                     s_sign_q, s_zsign_q, s_inv_q;
  logic [1:0]               s_spec_q;

  logic                     mul_sign_d, mul_zero_d, mul_inf_d, mul_nan_d;
  logic signed [11:0]       mul_exp_d;
  logic [SW-1:0]            mul_sig_d;
  logic [XW-1:0]            add_sum_d;
  logic signed [11:0]       add_exp_d;
  logic                     add_sign_d, add_zsign_d, add_inv_d;
  logic [1:0]               add_spec_d;
  logic [CWIDTH-1:0]        rnd_res_d;
  logic [2:0]               rnd_flg_d;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     len_hit;

  // MUL: exact significand product, normalised so the leading one sits at bit SW-1
  always_comb begin
    logic [EW-1:0]        ea, eb;
    logic [SIG_WIDTH-1:0] ma, mb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [PW-1:0]        prod;
    ea = a_q[WIDTH-2 -: EW];
    eb = b_q[WIDTH-2 -: EW];
    ma = a_q[SIG_WIDTH-1:0];
    mb = b_q[SIG_WIDTH-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    mul_sign_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    mul_nan_d  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
    mul_inf_d  = (a_inf | b_inf) & ~mul_nan_d;
    mul_zero_d = a_zero | b_zero;
    mul_exp_d  = $signed(12'(ea)) + $signed(12'(eb)) - 12'sd127 + (prod[PW-1] ? 12'sd1 : 12'sd0);
    mul_sig_d  = prod[PW-1] ? {prod, {(SW-PW){1'b0}}} : {prod[PW-2:0], {(SW-PW+1){1'b0}}};
  end

  // ADD: order operands by magnitude, align the smaller one with sticky, add or subtract
  always_comb begin
    logic [7:0]         ac_e;
    logic [SW-2:0]      ac_m;
    logic               ac_zero, ac_inf, ac_nan, p_big, lost;
    logic signed [11:0] ac_exp, big_exp, sml_exp, diff;
    logic [SW-1:0]      ac_sig, big_sig, sml_sig;
    logic               big_sign, sml_sign;
    logic [4:0]         sh;
    logic [XW-2:0]      sml_ext, sml_al;
    logic [XW-1:0]      big_ext, sml_x;
    ac_e    = acc_q[CWIDTH-2 -: 8];
    ac_m    = acc_q[SW-2:0];
    ac_zero = (ac_e == 8'h00);
    ac_inf  = (ac_e == 8'hFF) && (ac_m == '0);
    ac_nan  = (ac_e == 8'hFF) && (ac_m != '0);
    ac_exp  = $signed(12'(ac_e));
    ac_sig  = ac_zero ? '0 : {1'b1, ac_m};
    p_big   = !p_zero_q && (ac_zero || (p_exp_q > ac_exp) ||
              ((p_exp_q == ac_exp) && (p_sig_q > ac_sig)));
    big_exp  = p_big ? p_exp_q : ac_exp;
    sml_exp  = p_big ? ac_exp : p_exp_q;
    big_sig  = p_big ? p_sig_q : ac_sig;
    sml_sig  = p_big ? ac_sig : (p_zero_q ? '0 : p_sig_q);
    big_sign = p_big ? p_sign_q : acc_q[CWIDTH-1];
    sml_sign = p_big ? acc_q[CWIDTH-1] : p_sign_q;
    diff     = big_exp - sml_exp;
    sh       = ((diff < 12'sd0) || (diff > 12'sd27)) ? 5'd27 : diff[4:0];
    sml_ext  = {sml_sig, 3'b000};
    sml_al   = sml_ext >> sh;
    lost     = |(sml_ext & (((XW-1)'(1) << sh) - (XW-1)'(1)));
    big_ext  = {1'b0, big_sig, 3'b000};
    sml_x    = {1'b0, sml_al[XW-2:1], sml_al[0] | lost};
    add_sum_d  = (big_sign ^ sml_sign) ? (big_ext - sml_x) : (big_ext + sml_x);
    add_exp_d  = big_exp;
    add_sign_d = big_sign;
    if (p_zero_q && ac_zero)
      add_zsign_d = (rnd_q == 2'b11) ? (p_sign_q | acc_q[CWIDTH-1]) : (p_sign_q & acc_q[CWIDTH-1]);
    else
      add_zsign_d = (rnd_q == 2'b11);
    add_spec_d = 2'd0;
    add_inv_d  = 1'b0;
    if (p_nan_q || ac_nan || (p_inf_q && ac_inf && (p_sign_q != acc_q[CWIDTH-1]))) begin
      add_spec_d = 2'd1;
      add_inv_d  = 1'b1;
    end else if (p_inf_q) begin
      add_spec_d = 2'd2;
      add_sign_d = p_sign_q;
    end else if (ac_inf) begin
      add_spec_d = 2'd2;
      add_sign_d = acc_q[CWIDTH-1];
    end
  end

  // RND: normalise, round per latched mode, then resolve specials/overflow/underflow
  always_comb begin
    logic [4:0]         lp, shl;
    logic [XW-2:0]      norm;
    logic signed [11:0] ne;
    logic [SW-1:0]      mant;
    logic               g, rest, inc, to_inf;
    logic [SW:0]        m25;
    logic [SW-2:0]      mfin;
    lp = 5'd0;
    for (int i = 0; i < XW; i++)
      if (s_sum_q[i]) lp = 5'(i);
    shl = 5'd0;
    if (lp == 5'(XW-1)) begin
      norm = {s_sum_q[XW-1:2], s_sum_q[1] | s_sum_q[0]};
      ne   = s_exp_q + 12'sd1;
    end else begin
      shl  = 5'(XW-2) - lp;
      norm = (XW-1)'(s_sum_q << shl);
      ne   = s_exp_q - $signed(12'(shl));
    end
    mant = norm[XW-2:3];
    g    = norm[2];
    rest = |norm[1:0];
    case (rnd_q)
      2'b00:   inc = g & (rest | mant[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = (g | rest) & ~s_sign_q;
      default: inc = (g | rest) & s_sign_q;
    endcase
    m25 = {1'b0, mant} + (SW+1)'(inc);
    if (m25[SW]) begin
      mfin = m25[SW-1:1];
      ne   = ne + 12'sd1;
    end else begin
      mfin = m25[SW-2:0];
    end
    to_inf = (rnd_q == 2'b00) || ((rnd_q == 2'b10) && !s_sign_q) || ((rnd_q == 2'b11) && s_sign_q);
    rnd_flg_d = {s_inv_q, 2'b00};
    if (s_spec_q == 2'd1) begin
      rnd_res_d = 32'h7FC0_0000;
    end else if (s_spec_q == 2'd2) begin
      rnd_res_d = {s_sign_q, 8'hFF, 23'd0};
    end else if (s_sum_q == '0) begin
      rnd_res_d = {s_zsign_q, 31'd0};
    end else if (ne > 12'sd254) begin
      rnd_res_d    = to_inf ? {s_sign_q, 8'hFF, 23'd0} : {s_sign_q, 31'h7F7F_FFFF};
      rnd_flg_d[1] = 1'b1;
    end else if (ne < 12'sd1) begin
      rnd_res_d    = {s_sign_q, 31'd0};
      rnd_flg_d[0] = 1'b1;
    end else begin
      rnd_res_d = {s_sign_q, ne[7:0], mfin};
    end
  end

  assign cnt_inc = count_q + CNT_W'(1);
  assign len_hit = (cnt_inc == CNT_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_ACCEPT;
      first_q     <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      chain_q     <= '0;
      count_q     <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_valid && in_ready_q) begin
            a_q        <= A;
            b_q        <= B;
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            state_q    <= S_MUL;
            if (first_q) begin
              acc_q   <= c_sel ? C : chain_q;
              rnd_q   <= rnd;
              count_q <= '0;
              flags_q <= '0;
              first_q <= 1'b0;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_MUL: begin
          p_sign_q <= mul_sign_d;
          p_zero_q <= mul_zero_d;
          p_inf_q  <= mul_inf_d;
          p_nan_q  <= mul_nan_d;
          p_exp_q  <= mul_exp_d;
          p_sig_q  <= mul_sig_d;
          state_q  <= S_ADD;
        end
        S_ADD: begin
          s_sum_q   <= add_sum_d;
          s_exp_q   <= add_exp_d;
          s_sign_q  <= add_sign_d;
          s_zsign_q <= add_zsign_d;
          s_inv_q   <= add_inv_d;
          s_spec_q  <= add_spec_d;
          state_q   <= S_RND;
        end
        S_RND: begin
          acc_q   <= rnd_res_d;
          count_q <= cnt_inc;
          flags_q <= flags_q | {rnd_flg_d, len_hit & ~last_q};
          if (last_q || len_hit) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q    <= S_ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            chain_q     <= acc_q;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_ACCEPT;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign count     = count_q;
  assign flags     = flags_q;
endmodule

// File: doc/bf16_dot_acc.md
Name: bf16_dot_acc

Overview:
- Sequential BF16 dot-product engine. It streams (A,B) bfloat16 operand pairs and accumulates their products into an FP32 accumulator seeded by C, or by the previous result.
- It is the multi-cycle, handshaked successor of the single-shot FFPMAC.
- It adds vector length control, chained accumulation across vectors, sticky exception flags and all four rounding modes.
- It sits between the operand buffers and the FP32 result writeback in the BF-FPMAC datapath.

Parameters:
- WIDTH, 16, operand width (bfloat16: 1/8/7).
- SIG_WIDTH, 7, operand stored-fraction bits.
- CWIDTH, 32, accumulator/result width (FP32: 1/8/23).
- CSIG_WIDTH, 23, accumulator stored-fraction bits.
- MAX_LEN, 256, maximum elements per vector.
- CNT_W, 9, element counter width; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat.
- A, input, WIDTH, bf16 multiplicand.
- B, input, WIDTH, bf16 multiplier.
- C, input, CWIDTH, fp32 seed; sampled on the first beat only when c_sel=1.
- c_sel, input, 1, first-beat seed select: 1 = C, 0 = last delivered result (chain).
- in_last, input, 1, final beat of vector.
- rnd, input, 2, rounding mode, sampled on the first beat: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- result, output, CWIDTH, fp32 dot-product result.
- count, output, CNT_W, elements accumulated.
- flags, output, 4, {invalid, overflow, underflow, len_err}, sticky per vector.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to ACCEPT with first=1.
  - in_ready=0 during reset, 1 in the first cycle after.
  - out_valid=0, result=0, count=0, flags=0, chain register=0.
  - Reset mid-vector discards all partial state.
- FSM: ACCEPT -> MUL -> ADD -> RND -> (ACCEPT | DONE). DONE -> ACCEPT.
- in_ready=1 only in ACCEPT. A beat is accepted on in_valid & in_ready.
- Beat acceptance in ACCEPT:
  - Register A, B and in_last.
  - If first=1: load the accumulator from C (c_sel=1) or the chain register (c_sel=0), latch rnd, clear count/flags, set first=0.
- MUL:
  - Exact 8x8 significand product (16 bits), exponent eA+eB-127.
  - Sign = sA^sB.
  - Denormal operands are flushed to zero.
- ADD:
  - Align the product to the accumulator by exponent difference; shifted-out bits OR into sticky.
  - Signed-magnitude add/sub at CSIG_WIDTH+4 bits (guard/round/sticky).
- RND:
  - Leading-zero normalise, round per the latched rnd, write the accumulator, count+=1.
  - Then go to DONE if last (or forced), else ACCEPT.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+4. Throughput is 1 beat per 4 cycles.
- DONE:
  - out_valid=1; result, count and flags are stable until out_ready.
  - On out_valid & out_ready: chain register <= result, set first=1, go to ACCEPT.
  - out_valid drops the following cycle.
- Specials (IEEE semantics, quiet NaN output 0x7FC00000):
  - NaN on any operand -> NaN, invalid=1.
  - 0*inf -> NaN, invalid=1.
  - inf + (-inf) -> NaN, invalid=1.
  - inf propagates with correct sign.
  - Once the accumulator is NaN/inf it stays so for the rest of the vector.
- Overflow:
  - RNE, and the mode rounding away from the result sign: +/-inf.
  - RTZ, and the mode rounding toward zero for the result sign: +/-0x7F7FFFFF.
  - overflow=1 in all cases.
- Underflow: a result below 2^-126 flushes to signed zero, underflow=1.
- Exact cancellation gives +0, except RDN gives -0.
- Length guard: when count reaches MAX_LEN without in_last, that beat is treated as last and len_err=1.
- Vectors shorter than 1 element are impossible; a single in_last beat is a length-1 vector.
- in_valid while not in ACCEPT is ignored; upstream must hold the beat.

Test Plan:
1. Seeded dot, RNE: c_sel=1, C=0x3F800000, beats (A,B)=(0x4000,0x3F80),(0x4040,0x4000, last) -> result=0x41100000 (9.0), count=2, flags=0, out_valid at last-accept+4.
2. Chain: after test 1, c_sel=0, one beat (0x3F80,0x3F80, last) -> result=0x41200000 (10.0), count=1.
3. Cancellation: C=0x3F800000, beat (0x3F80,0xBF80, last); rnd=00 -> 0x00000000; rnd=11 -> 0x80000000.
4. Overflow: C=0x7F000000, beat (0x7F7F,0x4000, last); rnd=00 -> 0x7F800000, overflow=1; rnd=01 -> 0x7F7FFFFF, overflow=1.
5. Invalid: beat (0x7F80,0x0000, last) -> result=0x7FC00000, invalid=1. Backpressure check: hold out_ready=0 for 10 cycles; result and out_valid stay stable and in_ready stays 0.
6. Length guard and reset: MAX_LEN=4, 6 beats without in_last -> result after 4 beats, count=4, len_err=1. Separately, assert rst_n=0 mid-ADD -> next cycle out_valid=0, count=0, in_ready=1 once rst_n=1.
